// File: rtl/ss2_pkg.sv
// Shared SimpleSerial v2 definitions: framing constants, encoder state encoding
// and the byte-wide CRC-8 step used by both the encoder and the response decoder.
package ss2_pkg;

  localparam logic [7:0] SS2_DELIM    = 8'h00;
  localparam logic [7:0] SS2_HDR_LEN  = 8'd3;
  localparam logic [7:0] SS2_CRC_POLY = 8'h4D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CRC,
    ST_SCAN,
    ST_EMIT_CODE,
    ST_EMIT_DATA,
    ST_DELIM
  } state_t;

  // MSB-first, unreflected CRC-8 update of one byte.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly = SS2_CRC_POLY);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ss2_crc8.sv
// Registered CRC-8 accumulator: clear loads a seed, enable folds one byte per cycle.
module ss2_crc8
  import ss2_pkg::*;
#(
  parameter logic [7:0] pCRC_POLY = SS2_CRC_POLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] seed,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= seed;
    end else if (enable) begin
      crc <= crc8_byte(crc, data, pCRC_POLY);
    end
  end

endmodule

// File: rtl/ss2_frame_encoder.sv
// SimpleSerial v2 initiator frame builder: buffers header+payload, appends CRC-8,
// then streams the COBS encoding and a 0x00 delimiter over a valid/ready byte port.
module ss2_frame_encoder
  import ss2_pkg::*;
#(
  parameter int         pMAX_DATA = 64,
  parameter logic [7:0] pCRC_POLY = SS2_CRC_POLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd,
  input  logic [7:0] scmd,
  input  logic [7:0] dlen,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       error
);

  localparam int         DEPTH   = pMAX_DATA + 4;
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [7:0] MAX_LEN = 8'(pMAX_DATA);

  state_t     state;
  logic [7:0] mem [DEPTH];
  logic [7:0] dlen_q, wp, rp, sp;
  logic [7:0] n_len, rp_inc, hdr_crc, crc;
  logic       hdr_take, load_take, scan_hit;

  assign n_len     = dlen_q + 8'd4;
  assign rp_inc    = rp + 8'd1;
  assign hdr_take  = (state == ST_IDLE) && cmd_valid && (dlen <= MAX_LEN);
  assign load_take = (state == ST_LOAD) && in_valid;
  // A block ends at the first zero byte or at the end of the raw frame.
  assign scan_hit  = (sp == n_len) || (mem[sp[AW-1:0]] == SS2_DELIM);
  assign hdr_crc   = crc8_byte(crc8_byte(crc8_byte(8'h00, cmd, pCRC_POLY),
                                         scmd, pCRC_POLY), dlen, pCRC_POLY);

  assign cmd_ready = (state == ST_IDLE);
  assign in_ready  = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);

  ss2_crc8 #(.pCRC_POLY(pCRC_POLY)) u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (hdr_take),
    .seed   (hdr_crc),
    .enable (load_take),
    .data   (in_data),
    .crc    (crc)
  );

  // NOTE: the frame buffer has no reset; every byte is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (hdr_take) begin
      mem[AW'(0)] <= cmd;
      mem[AW'(1)] <= scmd;
      mem[AW'(2)] <= dlen;
    end
    if (load_take) mem[wp[AW-1:0]] <= in_data;
    if (state == ST_CRC) mem[wp[AW-1:0]] <= crc;
  end

  always_ff @(posedge clk) begin
    // NOTE: default-low assignment makes error a single-cycle pulse without extra state.
    error <= 1'b0;
    if (reset) begin
      state     <= ST_IDLE;
      dlen_q    <= '0;
      wp        <= '0;
      rp        <= '0;
      sp        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (dlen > MAX_LEN) begin
              error <= 1'b1;
            end else begin
              dlen_q <= dlen;
              wp     <= SS2_HDR_LEN;
              state  <= (dlen == 8'd0) ? ST_CRC : ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            wp <= wp + 8'd1;
            if (wp == dlen_q + 8'd2) state <= ST_CRC;
          end
        end
        ST_CRC: begin
          rp    <= '0;
          sp    <= '0;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_hit) begin
            out_data  <= sp - rp + 8'd1;
            out_valid <= 1'b1;
            state     <= ST_EMIT_CODE;
          end else begin
            sp <= sp + 8'd1;
          end
        end
        ST_EMIT_CODE: begin
          if (out_ready) begin
            if (sp != rp) begin
              out_data <= mem[rp[AW-1:0]];
              state    <= ST_EMIT_DATA;
            end else if (sp != n_len) begin
              rp        <= sp + 8'd1;
              sp        <= sp + 8'd1;
              out_valid <= 1'b0;
              state     <= ST_SCAN;
            end else begin
              out_data <= SS2_DELIM;
              state    <= ST_DELIM;
            end
          end
        end
        ST_EMIT_DATA: begin
          if (out_ready) begin
            if (rp_inc != sp) begin
              rp       <= rp_inc;
              out_data <= mem[rp_inc[AW-1:0]];
            end else if (sp != n_len) begin
              // The zero at sp is implied by the next code byte.
              rp        <= sp + 8'd1;
              sp        <= sp + 8'd1;
              out_valid <= 1'b0;
              state     <= ST_SCAN;
            end else begin
              out_data <= SS2_DELIM;
              state    <= ST_DELIM;
            end
          end
        end
        ST_DELIM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ss2_frame_encoder.sv
// Randomized directed bench for ss2_frame_encoder against a queue-based CRC/COBS model.
module tb_ss2_frame_encoder;

  localparam int         MAXD = 64;
  localparam logic [7:0] POLY = 8'h4D;

  typedef logic [7:0] bq_t[$];

  logic       clk, reset;
  logic       cmd_valid, in_valid, out_ready;
  logic [7:0] cmd, scmd, dlen, in_data;
  logic       cmd_ready, in_ready, out_valid, busy, error;
  logic [7:0] out_data;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bq_t pay_q, got_q, exp_q;

  ss2_frame_encoder #(.pMAX_DATA(MAXD), .pCRC_POLY(POLY)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .scmd      (scmd),
    .dlen      (dlen),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial LFSR view of the CRC: feedback = top bit xor message bit.
  function automatic logic [7:0] ref_crc(input bq_t msg);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ msg[i][b];
        r  = {r[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
      end
    end
    return r;
  endfunction

  // Raw frame -> COBS blocks -> delimiter, straight from the framing rules.
  task automatic build_expected(input logic [7:0] c, input logic [7:0] s);
    bq_t raw, blk;
    raw = {c, s, 8'(pay_q.size())};
    foreach (pay_q[i]) raw.push_back(pay_q[i]);
    raw.push_back(ref_crc(raw));
    exp_q.delete();
    blk.delete();
    foreach (raw[i]) begin
      if (raw[i] == 8'h00) begin
        exp_q.push_back(8'(blk.size() + 1));
        foreach (blk[j]) exp_q.push_back(blk[j]);
        blk.delete();
      end else begin
        blk.push_back(raw[i]);
      end
    end
    exp_q.push_back(8'(blk.size() + 1));
    foreach (blk[j]) exp_q.push_back(blk[j]);
    exp_q.push_back(8'h00);
  endtask

  task automatic make_payload(input int n, input int zero_pct);
    pay_q.delete();
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < zero_pct) pay_q.push_back(8'h00);
      else pay_q.push_back(8'($urandom_range(255, 1)));
    end
  endtask

  // Drives one frame and collects output handshakes; entered and left at posedge+1.
  // ready_mode: 0 always ready, 1 toggling, 2 random. abort_after>0 stops early.
  task automatic run_frame(input string tag, input logic [7:0] c, input logic [7:0] s,
                           input int ready_mode, input int gap_pct, input int abort_after);
    int         cyc = 0;
    int         pi = 0;
    bit         sent = 0, done = 0, stall = 0;
    logic [7:0] stall_data = '0;
    got_q.delete();
    cmd = c; scmd = s; dlen = 8'(pay_q.size()); cmd_valid = 1'b1;
    while (!done && cyc < 5000) begin
      if (pi < pay_q.size() && int'($urandom_range(99)) >= gap_pct) begin
        in_valid = 1'b1;
        in_data  = pay_q[pi];
      end else begin
        in_valid = 1'b0;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(1));
      endcase
      if (cmd_valid && cmd_ready) sent = 1;
      if (in_valid && in_ready) pi++;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (out_data == 8'h00) done = 1;
        if (abort_after > 0 && got_q.size() == abort_after) done = 1;
      end
      stall      = out_valid && !out_ready;
      stall_data = out_data;
      @(posedge clk); #1;
      cyc++;
      if (sent) cmd_valid = 1'b0;
      if (cyc == 1) check({tag, "_busy_rise"}, busy, 1'b1);
      if (stall) begin
        check({tag, "_stall_valid"}, out_valid, 1'b1);
        check({tag, "_stall_data"}, out_data, stall_data);
      end
      check({tag, "_ready_excl"}, in_ready & (cmd_ready | out_valid), 1'b0);
      if (sent && pi == pay_q.size()) check({tag, "_in_ready_off"}, in_ready, 1'b0);
    end
    in_valid = 1'b0;
    check({tag, "_completed"}, done, 1'b1);
    if (abort_after == 0) begin
      check({tag, "_busy_fall"}, busy, 1'b0);
      check({tag, "_cmd_ready_end"}, cmd_ready, 1'b1);
      check({tag, "_no_error"}, error, 1'b0);
      build_expected(c, s);
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    bq_t        raw;
    logic [7:0] last_v;
    reset = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cmd = '0; scmd = '0; dlen = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // All-zero empty frame: every byte is a zero, so five 0x01 codes.
    pay_q.delete();
    run_frame("zero", 8'h00, 8'h00, 0, 0, 0);

    // Known frame 01 00 00 06, streaming and then with toggling backpressure.
    pay_q.delete();
    run_frame("cmd01", 8'h01, 8'h00, 0, 0, 0);
    pay_q.delete();
    run_frame("cmd01_tog", 8'h01, 8'h00, 1, 0, 0);

    // Oversized length: one-cycle error, nothing emitted.
    cmd = 8'h5A; scmd = 8'h01; dlen = 8'(MAXD + 1); cmd_valid = 1'b1;
    check("err_before", error, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("err_pulse", error, 1'b1);
    check("err_cmd_ready", cmd_ready, 1'b1);
    check("err_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("err_clear", error, 1'b0);
    check("err_busy", busy, 1'b0);
    check("err_still_idle_valid", out_valid, 1'b0);
    make_payload(5, 20);
    run_frame("after_err", 8'($urandom), 8'($urandom), 0, 0, 0);

    // Four payload bytes with random input gaps and random backpressure.
    make_payload(4, 25);
    run_frame("gap4", 8'($urandom), 8'($urandom), 2, 40, 0);

    // Reset in the middle of emitting a long data block.
    make_payload(16, 0);
    run_frame("abort", 8'h11, 8'h22, 0, 0, 3);
    reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    check("abort_in_ready", in_ready, 1'b0);
    make_payload(16, 15);
    run_frame("post_abort", 8'($urandom), 8'($urandom), 2, 20, 0);

    // Payload chosen so the CRC is zero: trailing 0x01 code before the delimiter.
    make_payload(2, 0);
    raw = {8'h33, 8'h44, 8'd3};
    foreach (pay_q[i]) raw.push_back(pay_q[i]);
    last_v = 8'h00;
    for (int v = 0; v < 256; v++) begin
      raw.push_back(8'(v));
      if (ref_crc(raw) == 8'h00) last_v = 8'(v);
      void'(raw.pop_back());
    end
    pay_q.push_back(last_v);
    run_frame("crc_zero", 8'h33, 8'h44, 0, 0, 0);

    // Maximum payload, then a few random frames.
    make_payload(MAXD, 10);
    run_frame("max_len", 8'($urandom), 8'($urandom), 2, 10, 0);
    for (int f = 0; f < 5; f++) begin
      make_payload(int'($urandom_range(MAXD)), 30);
      run_frame($sformatf("rnd%0d", f), 8'($urandom), 8'($urandom), 2, 30, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
